// File: rtl/conv1_wm_loader_if.sv
// Weight stream bundle for conv1_wm_loader: the load-side valid/ready stream
// and the replay-side weight stream toward the MAC array.
interface conv1_wm_loader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  w_valid;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_last;
    logic                  w_ready;

    modport slave (
        input  load_valid, load_data, w_ready,
        output load_ready, w_valid, w_data, w_last
    );

    modport master (
        output load_valid, load_data, w_ready,
        input  load_ready, w_valid, w_data, w_last
    );
endinterface

// File: rtl/conv1_wm_loader.sv
// conv1 weight SRAM loader / replay sequencer with a 2-entry skid FIFO.
// Optional CONV1_WM_CHECKSUM_EN adds a load checksum and replay mismatch flag.
module conv1_wm_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_WORDS  = 100
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    conv1_wm_loader_if.slave      wm,
    input  logic                  clear,
    input  logic                  start,
    output logic                  loaded,
    output logic                  busy,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef CONV1_WM_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic                  chk_err
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED, S_STREAM} state_t;

    localparam int                  PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]       NUM_W   = PW'(NUM_WORDS);
    localparam logic [PW-1:0]       LAST_W  = PW'(NUM_WORDS - 1);
    localparam logic [PW-1:0]       PTR_ONE = PW'(1);

    state_t                  state_r;
    logic [PW-1:0]           wr_ptr_r;
    logic [PW-1:0]           rd_ptr_r;
    logic                    load_ready_r;
    logic                    loaded_r;
    logic                    busy_r;
    logic                    inflight_r;
    logic                    inflight_last_r;
    logic [DATA_WIDTH-1:0]   fifo_data_r [0:1];
    logic                    fifo_last_r [0:1];
    logic                    head_r;
    logic                    tail_r;
    logic [1:0]              count_r;

    logic                    load_fire_s;
    logic                    pop_s;
    logic                    last_pop_s;
    logic [2:0]              occ_s;
    logic                    issue_s;

    assign load_fire_s   = wm.load_valid && load_ready_r;
    assign wm.load_ready = load_ready_r;
    assign wm.w_valid    = (count_r != 2'd0);
    assign wm.w_data     = fifo_data_r[head_r];
    assign wm.w_last     = fifo_last_r[head_r];
    assign loaded        = loaded_r;
    assign busy          = busy_r;
    assign pop_s         = wm.w_valid && wm.w_ready;
    assign last_pop_s    = pop_s && wm.w_last;

    // A same-cycle pop frees a slot, which keeps the read port streaming at full rate.
    assign occ_s   = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s = (state_r == S_STREAM) && (rd_ptr_r < NUM_W) && (occ_s < 3'd2);

    // SRAM pin drive: write on an accepted beat, read on an issued replay access.
    always_comb begin
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = {ADDR_WIDTH{1'b0}};
        sram_din0  = {DATA_WIDTH{1'b0}};
        if (load_fire_s) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = wr_ptr_r[ADDR_WIDTH-1:0];
            sram_din0  = wm.load_data;
        end else if (issue_s) begin
            sram_csb0  = 1'b0;
            sram_addr0 = rd_ptr_r[ADDR_WIDTH-1:0];
        end else begin
            sram_csb0  = 1'b1;
            sram_web0  = 1'b1;
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            load_ready_r <= 1'b0;
            loaded_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_LOAD: begin
                    load_ready_r <= 1'b1;
                    if (load_fire_s) begin
                        if (wr_ptr_r == LAST_W) begin
                            wr_ptr_r     <= {PW{1'b0}};
                            state_r      <= S_LOADED;
                            load_ready_r <= 1'b0;
                            loaded_r     <= 1'b1;
                        end else begin
                            wr_ptr_r <= wr_ptr_r + PTR_ONE;
                            state_r  <= S_LOAD;
                        end
                    end
                end
                S_LOADED: begin
                    if (clear) begin
                        state_r      <= S_IDLE;
                        loaded_r     <= 1'b0;
                        load_ready_r <= 1'b1;
                    end else if (start) begin
                        state_r  <= S_STREAM;
                        rd_ptr_r <= {PW{1'b0}};
                        busy_r   <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (issue_s) begin
                        rd_ptr_r <= rd_ptr_r + PTR_ONE;
                    end
                    if (last_pop_s) begin
                        state_r <= S_LOADED;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    load_ready_r <= 1'b0;
                    loaded_r     <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    // Read-latency tracking and the 2-entry skid FIFO.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
            fifo_data_r[0]  <= {DATA_WIDTH{1'b0}};
            fifo_data_r[1]  <= {DATA_WIDTH{1'b0}};
            fifo_last_r[0]  <= 1'b0;
            fifo_last_r[1]  <= 1'b0;
            head_r          <= 1'b0;
            tail_r          <= 1'b0;
            count_r         <= 2'd0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && (rd_ptr_r == LAST_W);
            if (inflight_r) begin
                fifo_data_r[tail_r] <= sram_dout0;
                fifo_last_r[tail_r] <= inflight_last_r;
                tail_r              <= ~tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
            count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

`ifdef CONV1_WM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_r;
    logic [DATA_WIDTH-1:0] replay_sum_r;
    logic                  chk_err_r;

    assign checksum = checksum_r;
    assign chk_err  = chk_err_r;

    // Load checksum and per-replay sum comparison at the w_last pop.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            checksum_r   <= {DATA_WIDTH{1'b0}};
            replay_sum_r <= {DATA_WIDTH{1'b0}};
            chk_err_r    <= 1'b0;
        end else if (state_r == S_LOADED && clear) begin
            checksum_r   <= {DATA_WIDTH{1'b0}};
            replay_sum_r <= {DATA_WIDTH{1'b0}};
            chk_err_r    <= 1'b0;
        end else if (state_r == S_LOADED && start) begin
            replay_sum_r <= {DATA_WIDTH{1'b0}};
            chk_err_r    <= 1'b0;
        end else begin
            if (load_fire_s) begin
                checksum_r <= checksum_r + wm.load_data;
            end
            if (pop_s) begin
                replay_sum_r <= replay_sum_r + wm.w_data;
            end
            if (last_pop_s) begin
                chk_err_r <= ((replay_sum_r + wm.w_data) != checksum_r);
            end
        end
    end
`endif
endmodule

// File: tb/tb_conv1_wm_loader.sv
// Self-checking bench for conv1_wm_loader: table-driven load checks plus
// hand-written replay, back-pressure, reset and start/clear sequences.
module tb_conv1_wm_loader;
    localparam int DW = 16;
    localparam int AW = 7;
    localparam int NW = 100;

    logic          clk0 = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          start;
    logic          loaded;
    logic          busy;
    logic          sram_csb0;
    logic          sram_web0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;
`ifdef CONV1_WM_CHECKSUM_EN
    logic [DW-1:0] checksum;
    logic          chk_err;
`endif

    conv1_wm_loader_if #(.DATA_WIDTH(DW)) wm_bus ();

    conv1_wm_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW)) dut (
        .clk0       (clk0),
        .rst_n      (rst_n),
        .wm         (wm_bus),
        .clear      (clear),
        .start      (start),
        .loaded     (loaded),
        .busy       (busy),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
`ifdef CONV1_WM_CHECKSUM_EN
        ,
        .checksum   (checksum),
        .chk_err    (chk_err)
`endif
    );

    always #5 clk0 = ~clk0;

    // Behavioural single-port SRAM with one-cycle read latency and a bit-0 fault injector.
    logic [DW-1:0] mem [0:127];
    int            fault_addr = -1;
    always @(posedge clk0) begin
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else sram_dout0 <= mem[sram_addr0] ^ ((int'(sram_addr0) == fault_addr) ? 16'h0001 : 16'h0000);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {load_ready, loaded, busy, w_valid, csb0, web0, addr0, din0}
    function automatic logic [31:0] obs();
        return {3'b000, wm_bus.load_ready, loaded, busy, wm_bus.w_valid,
                sram_csb0, sram_web0, sram_addr0, sram_din0};
    endfunction

    function automatic logic [31:0] pack(input logic lr, input logic ld, input logic bz,
                                         input logic wv, input logic cs, input logic we,
                                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        return {3'b000, lr, ld, bz, wv, cs, we, a, d};
    endfunction

    typedef struct {
        logic          lv;
        logic [DW-1:0] ld;
        logic          st;
        logic          cl;
        logic [31:0]   exp;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic replay(input int toggle, input int data_mode, input int fault_idx, input int stop_at);
        int idx = 0, cyc = 0, issued = 0, popped = 0, maxout = 0, first_valid = -1, last_edge = -1;
        bit done = 1'b0;
        logic [DW-1:0] exp_d;
        start = 1'b1;
        step();
        start = 1'b0;
        while (!done && cyc < 2000) begin
            wm_bus.w_ready = (toggle != 0) ? (cyc % 3 == 0) : 1'b1;
            @(negedge clk0);
            if (issued - popped > maxout) maxout = issued - popped;
            if (first_valid < 0 && wm_bus.w_valid) first_valid = cyc;
            if (!sram_csb0 && sram_web0) issued++;
            if (wm_bus.w_valid && wm_bus.w_ready) begin
                if (data_mode != 0) exp_d = (idx == fault_idx) ? 16'h0100 : 16'h0101;
                else exp_d = DW'(idx);
                chk("w_data", {15'd0, wm_bus.w_last, wm_bus.w_data}, {15'd0, (idx == NW - 1), exp_d});
                if (wm_bus.w_last) begin
                    done = 1'b1;
                    last_edge = cyc + 1;
                end
                popped++;
                idx++;
                if (stop_at > 0 && idx == stop_at) done = 1'b1;
            end
            @(posedge clk0);
            #1;
            cyc++;
        end
        wm_bus.w_ready = 1'b0;
        if (stop_at > 0) begin
            chk("stop_reached", 32'(idx), 32'(stop_at));
        end else begin
            chk("replay_done", {31'd0, done}, 32'd1);
            chk("first_valid_cycle", 32'(first_valid), 32'd2);
            chk("word_count", 32'(idx), 32'(NW));
            chk("max_outstanding_le2", {31'd0, (maxout <= 2)}, 32'd1);
            if (toggle == 0) chk("last_pop_edge", 32'(last_edge), 32'(NW + 2));
            @(negedge clk0);
            chk("post_replay_status", {29'd0, loaded, busy, wm_bus.w_valid}, 32'b100);
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; clear = 1'b0; start = 1'b0;
        wm_bus.load_valid = 1'b0; wm_bus.load_data = 16'h0000; wm_bus.w_ready = 1'b0;

        v.lv = 1'b0; v.ld = 16'h0000; v.st = 1'b1; v.cl = 1'b0;
        v.exp = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 16'h0000);
        vecs.push_back(v);
        for (int i = 0; i < NW; i++) begin
            v.lv = 1'b1; v.ld = DW'(i); v.st = 1'b0; v.cl = (i == 50);
            v.exp = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, AW'(i), DW'(i));
            vecs.push_back(v);
        end
        v.lv = 1'b1; v.ld = 16'hBEEF; v.st = 1'b0; v.cl = 1'b0;
        v.exp = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 16'h0000);
        vecs.push_back(v);

        step();
        step();
        chk("reset_state", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 16'h0000));
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            wm_bus.load_valid = vecs[i].lv;
            wm_bus.load_data  = vecs[i].ld;
            start             = vecs[i].st;
            clear             = vecs[i].cl;
            @(negedge clk0);
            chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
            step();
        end
        wm_bus.load_valid = 1'b0; start = 1'b0; clear = 1'b0;

        replay(0, 0, -1, 0);
        replay(0, 0, -1, 0);
        replay(1, 0, -1, 0);

        // Reset in the middle of a replay pass.
        replay(0, 0, -1, 40);
        rst_n = 1'b0;
        #1;
        chk("midstream_reset", obs(), pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'd0, 16'h0000));
        step();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < NW; i++) begin
            wm_bus.load_valid = 1'b1;
            wm_bus.load_data  = DW'(i);
            @(negedge clk0);
            if (i == 0) chk("reload_first_write", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 16'h0000));
            step();
        end
        wm_bus.load_valid = 1'b0;
        chk("reloaded", {31'd0, loaded}, 32'd1);

        // start and clear together in LOADED: clear wins, no read issued.
        start = 1'b1; clear = 1'b1;
        @(negedge clk0);
        chk("start_clear_no_read", {31'd0, sram_csb0}, 32'd1);
        step();
        start = 1'b0; clear = 1'b0;
        @(negedge clk0);
        chk("start_clear_idle", {28'd0, loaded, busy, wm_bus.load_ready, sram_csb0}, 32'b0011);
        step();

        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk0);
        chk("start_in_idle_ignored", {28'd0, loaded, busy, wm_bus.load_ready, sram_csb0}, 32'b0011);
        step();

`ifdef CONV1_WM_CHECKSUM_EN
        for (int i = 0; i < NW; i++) begin
            wm_bus.load_valid = 1'b1;
            wm_bus.load_data  = 16'h0101;
            step();
        end
        wm_bus.load_valid = 1'b0;
        chk("checksum", {16'd0, checksum}, 32'h6464);
        replay(0, 1, -1, 0);
        chk("chk_err_clean", {31'd0, chk_err}, 32'd0);
        fault_addr = 5;
        replay(0, 1, 5, 0);
        fault_addr = -1;
        chk("chk_err_fault", {31'd0, chk_err}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
